// File: rtl/gpr_file.sv
// 32-entry general-purpose register file: two combinational read ports, one write-back port,
// cleared by a post-reset sweep. Optional macro GPR_FILE_REG_BYPASS_EN adds write-to-read forwarding.
module gpr_file #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned NUM_REGS   = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  reg_read_en_1,
  input  logic [ADDR_WIDTH-1:0] reg_addr_1,
  output logic [DATA_WIDTH-1:0] reg_data_1,
  input  logic                  reg_read_en_2,
  input  logic [ADDR_WIDTH-1:0] reg_addr_2,
  output logic [DATA_WIDTH-1:0] reg_data_2,
  input  logic                  write_reg_en,
  input  logic [ADDR_WIDTH-1:0] write_reg_addr,
  input  logic [DATA_WIDTH-1:0] write_reg_data,
  output logic                  init_done
);

  typedef enum logic [0:0] {StInit, StRun} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] sweep_ptr_q, sweep_ptr_d;
  logic                  init_done_q, init_done_d;
  logic [DATA_WIDTH-1:0] mem_q [NUM_REGS];

  logic                  sweep_last;
  logic                  wb_we;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;

  assign sweep_last = (sweep_ptr_q == ADDR_WIDTH'(NUM_REGS - 1));
  assign init_done  = init_done_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StInit;
      sweep_ptr_q <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sweep_ptr_q <= sweep_ptr_d;
      init_done_q <= init_done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    sweep_ptr_d = sweep_ptr_q;
    init_done_d = init_done_q;
    case (state_q)
      StInit: begin
        sweep_ptr_d = sweep_ptr_q + ADDR_WIDTH'(1);
        if (sweep_last) begin
          state_d     = StRun;
          init_done_d = 1'b1;
        end
      end
      StRun:   state_d = StRun;
      default: state_d = StInit;
    endcase
  end

  // Single write port shared by the sweep and write-back keeps the array RAM-mappable.
  always_comb begin
    wb_we     = (state_q == StRun) && !rst && write_reg_en && (write_reg_addr != '0);
    mem_we    = wb_we;
    mem_waddr = write_reg_addr;
    mem_wdata = write_reg_data;
    if (state_q == StInit) begin
      mem_we    = !rst;
      mem_waddr = sweep_ptr_q;
      mem_wdata = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  always_comb begin
    reg_data_1 = mem_q[reg_addr_1];
    reg_data_2 = mem_q[reg_addr_2];
`ifdef GPR_FILE_REG_BYPASS_EN
    if (wb_we && (write_reg_addr == reg_addr_1)) reg_data_1 = write_reg_data;
    if (wb_we && (write_reg_addr == reg_addr_2)) reg_data_2 = write_reg_data;
`endif
    // Zeroing last so the $0/disable/reset rules override any forwarded value.
    if (rst || !reg_read_en_1 || (reg_addr_1 == '0) || (state_q == StInit)) reg_data_1 = '0;
    if (rst || !reg_read_en_2 || (reg_addr_2 == '0) || (state_q == StInit)) reg_data_2 = '0;
  end

endmodule

// File: tb/tb_gpr_file.sv
// Scoreboard bench for gpr_file: driver pushes expected read/init_done values each cycle,
// a negedge monitor pops and compares them.
module tb_gpr_file;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        reg_read_en_1 = 1'b0;
  logic [4:0]  reg_addr_1 = '0;
  logic [31:0] reg_data_1;
  logic        reg_read_en_2 = 1'b0;
  logic [4:0]  reg_addr_2 = '0;
  logic [31:0] reg_data_2;
  logic        write_reg_en = 1'b0;
  logic [4:0]  write_reg_addr = '0;
  logic [31:0] write_reg_data = '0;
  logic        init_done;

  always #5 clk = ~clk;

  gpr_file #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(5),
    .NUM_REGS  (32)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .reg_read_en_1 (reg_read_en_1),
    .reg_addr_1    (reg_addr_1),
    .reg_data_1    (reg_data_1),
    .reg_read_en_2 (reg_read_en_2),
    .reg_addr_2    (reg_addr_2),
    .reg_data_2    (reg_data_2),
    .write_reg_en  (write_reg_en),
    .write_reg_addr(write_reg_addr),
    .write_reg_data(write_reg_data),
    .init_done     (init_done)
  );

  typedef struct {
    string       nm;
    logic [31:0] d1;
    logic [31:0] d2;
    logic        dn;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  logic chk_vld = 1'b0;

`ifdef GPR_FILE_REG_BYPASS_EN
  localparam logic [31:0] Same7 = 32'h2222_2222;
`else
  localparam logic [31:0] Same7 = 32'h1111_1111;
`endif

  function automatic logic [31:0] fill_val(input int i);
    logic [31:0] v;
    v = 32'hC0DE_0000 | (32'(i) << 8) | 32'(i);
    return v;
  endfunction

  // Drive one cycle of inputs and queue what the DUT must show for it.
  task automatic step(input string nm, input logic r,
                      input logic e1, input logic [4:0] a1,
                      input logic e2, input logic [4:0] a2,
                      input logic we, input logic [4:0] wa, input logic [31:0] wd,
                      input logic [31:0] x1, input logic [31:0] x2, input logic xd);
    exp_t e;
    @(posedge clk);
    #1;
    rst            = r;
    reg_read_en_1  = e1;
    reg_addr_1     = a1;
    reg_read_en_2  = e2;
    reg_addr_2     = a2;
    write_reg_en   = we;
    write_reg_addr = wa;
    write_reg_data = wd;
    e.nm = nm;
    e.d1 = x1;
    e.d2 = x2;
    e.dn = xd;
    sb.push_back(e);
    chk_vld = 1'b1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (chk_vld) begin
      n_vec++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL scoreboard_empty: got output with no expected entry");
      end else begin
        e = sb.pop_front();
        if (reg_data_1 !== e.d1) begin
          n_err++;
          $display("FAIL %s data_1: got %h want %h", e.nm, reg_data_1, e.d1);
        end
        if (reg_data_2 !== e.d2) begin
          n_err++;
          $display("FAIL %s data_2: got %h want %h", e.nm, reg_data_2, e.d2);
        end
        if (init_done !== e.dn) begin
          n_err++;
          $display("FAIL %s init_done: got %b want %b", e.nm, init_done, e.dn);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held for two edges, then release and watch the 32-cycle sweep.
    step("rst_a", 1'b1, 1, 5'd1, 1, 5'd2, 0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0);
    step("rst_b", 1'b0, 1, 5'd1, 1, 5'd2, 0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0);
    for (int k = 1; k <= 32; k++) begin
      step("sweep", 1'b0, 1, 5'(k), 1, 5'(k + 7), 0, 5'd0, 32'h0,
           32'h0, 32'h0, (k == 32));
    end
    for (int i = 0; i < 32; i++) begin
      step("clear", 1'b0, 1, 5'(i), 1, 5'(31 - i), 0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b1);
    end

    step("wr5", 1'b0, 0, 5'd5, 0, 5'd5, 1, 5'd5, 32'hDEAD_BEEF, 32'h0, 32'h0, 1'b1);
    step("rd5", 1'b0, 1, 5'd5, 1, 5'd5, 0, 5'd0, 32'h0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1);

    step("wr0", 1'b0, 0, 5'd0, 0, 5'd0, 1, 5'd0, 32'hFFFF_FFFF, 32'h0, 32'h0, 1'b1);
    step("rd0", 1'b0, 1, 5'd0, 1, 5'd0, 0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b1);

    step("wr7a", 1'b0, 0, 5'd0, 0, 5'd0, 1, 5'd7, 32'h1111_1111, 32'h0, 32'h0, 1'b1);
    step("wr7b", 1'b0, 1, 5'd7, 1, 5'd5, 1, 5'd7, 32'h2222_2222, Same7, 32'hDEAD_BEEF, 1'b1);
    step("rd7", 1'b0, 1, 5'd7, 1, 5'd7, 0, 5'd0, 32'h0, 32'h2222_2222, 32'h2222_2222, 1'b1);

    step("wr3", 1'b0, 0, 5'd0, 0, 5'd0, 1, 5'd3, 32'hA5A5_A5A5, 32'h0, 32'h0, 1'b1);
    step("rd3", 1'b0, 0, 5'd3, 1, 5'd3, 0, 5'd0, 32'h0, 32'h0, 32'hA5A5_A5A5, 1'b1);

    // Fill, then reset mid-RUN with stray writes during the sweep.
    for (int i = 1; i < 32; i++) begin
      step("fill", 1'b0, 1, 5'(i - 1), 0, 5'd0, 1, 5'(i), fill_val(i),
           (i == 1) ? 32'h0 : fill_val(i - 1), 32'h0, 1'b1);
    end
    for (int i = 0; i < 32; i++) begin
      step("fill_rd", 1'b0, 1, 5'(i), 1, 5'(31 - i), 0, 5'd0, 32'h0,
           (i == 0) ? 32'h0 : fill_val(i), (i == 31) ? 32'h0 : fill_val(31 - i), 1'b1);
    end
    step("rst2_a", 1'b1, 1, 5'd9, 1, 5'd9, 0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b1);
    step("rst2_b", 1'b0, 1, 5'd9, 1, 5'd9, 0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0);
    for (int k = 1; k <= 32; k++) begin
      step("sweep2", 1'b0, 1, 5'd9, 1, 5'd2, (k == 3) || (k == 31),
           (k == 3) ? 5'd9 : 5'd2, 32'h0000_1234, 32'h0, 32'h0, (k == 32));
    end
    for (int i = 0; i < 32; i++) begin
      step("clear2", 1'b0, 1, 5'(i), 1, 5'(31 - i), 0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b1);
    end

    @(negedge clk);
    #1;
    chk_vld = 1'b0;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d left want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
